apb3_uart_arbiter: RTL and testbench

Two-requester APB3 arbiter that shares the single APB3 completer port of the UART between two requesters. Typical pairing: the Renode-driven bus requester and an on-chip UART configuration/traffic sequencer. Each requester sees a standard APB3 completer interface and is stalled with PREADY=0 until it is served. The downstream side is a clean APB3 requester that issues a fresh SETUP/ACCESS sequence per granted transfer. Arbitration is round-robin with whole-transfer granularity.

---
 rtl/apb3_uart_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb3_uart_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/apb3_uart_arbiter.sv
// Round-robin arbiter that shares one APB3 UART completer between two APB3 requesters.
// Optional ACCESS-phase abort after TimeoutCycles wait cycles when ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no transfer owned; arbitrate among requesters with PSEL=1
// SETUP  | downstream SETUP phase from latched request
// ACCESS | downstream ACCESS phase, waiting for S_PREADY
// RESP   | one-cycle PREADY to the owner, then pointer flips
module apb3_uart_arbiter #(
  parameter int ApbAddrWidth  = 32,
  parameter int ApbDataWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    M0_PSEL,
  input  logic                    M0_PENABLE,
  input  logic                    M0_PWRITE,
  input  logic [ApbAddrWidth-1:0] M0_PADDR,
  input  logic [ApbDataWidth-1:0] M0_PWDATA,
  output logic [ApbDataWidth-1:0] M0_PRDATA,
  output logic                    M0_PREADY,
  output logic                    M0_PSLVERR,
  input  logic                    M1_PSEL,
  input  logic                    M1_PENABLE,
  input  logic                    M1_PWRITE,
  input  logic [ApbAddrWidth-1:0] M1_PADDR,
  input  logic [ApbDataWidth-1:0] M1_PWDATA,
  output logic [ApbDataWidth-1:0] M1_PRDATA,
  output logic                    M1_PREADY,
  output logic                    M1_PSLVERR,
  output logic                    S_PSEL,
  output logic                    S_PENABLE,
  output logic                    S_PWRITE,
  output logic [ApbAddrWidth-1:0] S_PADDR,
  output logic [ApbDataWidth-1:0] S_PWDATA,
  input  logic [ApbDataWidth-1:0] S_PRDATA,
  input  logic                    S_PREADY,
  input  logic                    S_PSLVERR,
  output logic [1:0]              GNT
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    ptr_q;
  logic                    owner_q;
  logic                    drop_q;
  logic [1:0]              gnt_q;
  logic                    pwrite_q;
  logic [ApbAddrWidth-1:0] addr_q;
  logic [ApbDataWidth-1:0] wdata_q;
  logic [ApbDataWidth-1:0] rdata_q;
  logic                    slverr_q;
  logic                    req_any;
  logic                    pick1;
  logic                    owner_psel;
  logic                    timeout_hit;
  logic                    resp_ok;
  logic                    unused_pen;

  assign unused_pen = M0_PENABLE ^ M1_PENABLE;
  assign req_any    = M0_PSEL | M1_PSEL;
  // ptr_q=1 favours M1 when both request
  assign pick1      = M1_PSEL & (~M0_PSEL | ptr_q);
  assign owner_psel = owner_q ? M1_PSEL : M0_PSEL;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TimeoutCycles - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST)                               tmo_cnt_q <= '0;
    else if (state_q == SETUP)             tmo_cnt_q <= '0;
    else if (state_q == ACCESS && !S_PREADY) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign timeout_hit = (state_q == ACCESS) && !S_PREADY && (tmo_cnt_q == TmoLast);
`else
  logic [15:0] unused_tmo;
  assign unused_tmo  = 16'(TimeoutCycles);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (S_PREADY || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      drop_q   <= 1'b0;
      gnt_q    <= 2'b00;
      pwrite_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_any) begin
          owner_q  <= pick1;
          gnt_q    <= pick1 ? 2'b10 : 2'b01;
          drop_q   <= 1'b0;
          pwrite_q <= pick1 ? M1_PWRITE : M0_PWRITE;
          addr_q   <= pick1 ? M1_PADDR  : M0_PADDR;
          wdata_q  <= pick1 ? M1_PWDATA : M0_PWDATA;
        end
        SETUP: if (!owner_psel) drop_q <= 1'b1;
        ACCESS: begin
          if (!owner_psel) drop_q <= 1'b1;
          if (S_PREADY) begin
            rdata_q  <= pwrite_q ? '0 : S_PRDATA;
            slverr_q <= S_PSLVERR;
          end else if (timeout_hit) begin
            rdata_q  <= '0;
            slverr_q <= 1'b1;
          end
        end
        RESP: begin
          ptr_q <= ~owner_q;
          gnt_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Everything below decodes flops only; an abandoned transfer suppresses PREADY
  always_comb begin
    resp_ok    = (state_q == RESP) && !drop_q;
    S_PSEL     = (state_q == SETUP) || (state_q == ACCESS);
    S_PENABLE  = (state_q == ACCESS);
    S_PWRITE   = pwrite_q;
    S_PADDR    = addr_q;
    S_PWDATA   = wdata_q;
    GNT        = gnt_q;
    M0_PREADY  = resp_ok && !owner_q;
    M1_PREADY  = resp_ok && owner_q;
    M0_PRDATA  = M0_PREADY ? rdata_q : '0;
    M1_PRDATA  = M1_PREADY ? rdata_q : '0;
    M0_PSLVERR = M0_PREADY && slverr_q;
    M1_PSLVERR = M1_PREADY && slverr_q;
  end

endmodule

// File: tb/tb_apb3_uart_arbiter.sv
// Directed bench for apb3_uart_arbiter: cycle table for reset/read/contention,
// hand sequences for wait states, dropped PSEL, mid-transfer reset and timeout.
module tb_apb3_uart_arbiter;

  logic        CLK, RST;
  logic        M0_PSEL, M0_PENABLE, M0_PWRITE, M0_PREADY, M0_PSLVERR;
  logic [31:0] M0_PADDR, M0_PWDATA, M0_PRDATA;
  logic        M1_PSEL, M1_PENABLE, M1_PWRITE, M1_PREADY, M1_PSLVERR;
  logic [31:0] M1_PADDR, M1_PWDATA, M1_PRDATA;
  logic        S_PSEL, S_PENABLE, S_PWRITE, S_PREADY, S_PSLVERR;
  logic [31:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [1:0]  GNT;

  int checks = 0;
  int errors = 0;

  apb3_uart_arbiter #(.ApbAddrWidth(32), .ApbDataWidth(32), .TimeoutCycles(4)) dut (
    .CLK(CLK), .RST(RST),
    .M0_PSEL(M0_PSEL), .M0_PENABLE(M0_PENABLE), .M0_PWRITE(M0_PWRITE), .M0_PADDR(M0_PADDR),
    .M0_PWDATA(M0_PWDATA), .M0_PRDATA(M0_PRDATA), .M0_PREADY(M0_PREADY), .M0_PSLVERR(M0_PSLVERR),
    .M1_PSEL(M1_PSEL), .M1_PENABLE(M1_PENABLE), .M1_PWRITE(M1_PWRITE), .M1_PADDR(M1_PADDR),
    .M1_PWDATA(M1_PWDATA), .M1_PRDATA(M1_PRDATA), .M1_PREADY(M1_PREADY), .M1_PSLVERR(M1_PSLVERR),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE), .S_PADDR(S_PADDR),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .GNT(GNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // inputs for one cycle, then outputs expected after the following rising edge
  typedef struct {
    logic [31:0] rst, p0, w0, a0, d0, p1, w1, a1, d1, rdy, rdat, err;
    logic [31:0] e_sel, e_en, e_wr, e_adr, e_wd, e_gnt, e_r0, e_d0, e_x0, e_r1, e_d1, e_x1;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_m0(input logic sel, input logic wr, input logic [31:0] a, input logic [31:0] d);
    M0_PSEL = sel; M0_PENABLE = sel; M0_PWRITE = wr; M0_PADDR = a; M0_PWDATA = d;
  endtask

  task automatic set_m1(input logic sel, input logic wr, input logic [31:0] a, input logic [31:0] d);
    M1_PSEL = sel; M1_PENABLE = sel; M1_PWRITE = wr; M1_PADDR = a; M1_PWDATA = d;
  endtask

  task automatic set_s(input logic rdy, input logic [31:0] rd, input logic err);
    S_PREADY = rdy; S_PRDATA = rd; S_PSLVERR = err;
  endtask

  initial begin
    RST = 1'b1;
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    set_s(0, 0, 0);

    // reset with both requesting
    vecs[0] = '{1,1,0,0,0, 1,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0};
    vecs[1] = vecs[0];
    // M0 reads 0x4 (M1 write to 0x8 waiting), then M1 served
    vecs[2] = '{0,1,0,4,0, 1,1,8,'h33, 0,0,0,      1,0,0,4,0,1,     0,0,0,    0,0,0};
    vecs[3] = '{0,1,0,4,0, 1,1,8,'h33, 0,0,0,      1,1,0,4,0,1,     0,0,0,    0,0,0};
    vecs[4] = '{0,1,0,4,0, 1,1,8,'h33, 1,'hA5,0,   0,0,0,0,0,1,     1,'hA5,0, 0,0,0};
    vecs[5] = '{0,0,0,0,0, 1,1,8,'h33, 0,0,0,      0,0,0,0,0,0,     0,0,0,    0,0,0};
    vecs[6] = '{0,0,0,0,0, 1,1,8,'h33, 0,0,0,      1,0,1,8,'h33,2,  0,0,0,    0,0,0};
    vecs[7] = '{0,0,0,0,0, 1,1,8,'h33, 0,0,0,      1,1,1,8,'h33,2,  0,0,0,    0,0,0};
    vecs[8] = '{0,0,0,0,0, 1,1,8,'h33, 1,'hDEAD,0, 0,0,0,0,0,2,     0,0,0,    1,0,0};
    vecs[9] = '{0,0,0,0,0, 0,0,0,0,    0,0,0,      0,0,0,0,0,0,     0,0,0,    0,0,0};
    // both write continuously: M0 0x11, M1 0x22, alternating
    for (int k = 0; k < 4; k++) begin
      logic [31:0] wd, g, r0, r1;
      wd = (k % 2 == 0) ? 32'h11 : 32'h22;
      g  = (k % 2 == 0) ? 32'd1 : 32'd2;
      r0 = (k % 2 == 0) ? 32'd1 : 32'd0;
      r1 = (k % 2 == 0) ? 32'd0 : 32'd1;
      vecs[10+4*k] = '{0,1,1,0,'h11, 1,1,0,'h22, 0,0,0, 1,0,1,0,wd,g, 0,0,0, 0,0,0};
      vecs[11+4*k] = '{0,1,1,0,'h11, 1,1,0,'h22, 0,0,0, 1,1,1,0,wd,g, 0,0,0, 0,0,0};
      vecs[12+4*k] = '{0,1,1,0,'h11, 1,1,0,'h22, 1,0,0, 0,0,0,0,0,g,  r0,0,0, r1,0,0};
      vecs[13+4*k] = '{0,1,1,0,'h11, 1,1,0,'h22, 0,0,0, 0,0,0,0,0,0,  0,0,0, 0,0,0};
    end
    vecs[25].p0 = 0;
    vecs[25].p1 = 0;

    for (int i = 0; i < 26; i++) begin
      RST = vecs[i].rst[0];
      set_m0(vecs[i].p0[0], vecs[i].w0[0], vecs[i].a0, vecs[i].d0);
      set_m1(vecs[i].p1[0], vecs[i].w1[0], vecs[i].a1, vecs[i].d1);
      set_s(vecs[i].rdy[0], vecs[i].rdat, vecs[i].err[0]);
      tick();
      chk($sformatf("v%0d S_PSEL", i), 32'(S_PSEL), vecs[i].e_sel);
      chk($sformatf("v%0d S_PENABLE", i), 32'(S_PENABLE), vecs[i].e_en);
      chk($sformatf("v%0d GNT", i), 32'(GNT), vecs[i].e_gnt);
      chk($sformatf("v%0d M0_PREADY", i), 32'(M0_PREADY), vecs[i].e_r0);
      chk($sformatf("v%0d M0_PRDATA", i), M0_PRDATA, vecs[i].e_d0);
      chk($sformatf("v%0d M0_PSLVERR", i), 32'(M0_PSLVERR), vecs[i].e_x0);
      chk($sformatf("v%0d M1_PREADY", i), 32'(M1_PREADY), vecs[i].e_r1);
      chk($sformatf("v%0d M1_PRDATA", i), M1_PRDATA, vecs[i].e_d1);
      chk($sformatf("v%0d M1_PSLVERR", i), 32'(M1_PSLVERR), vecs[i].e_x1);
      if (vecs[i].e_sel[0]) begin
        chk($sformatf("v%0d S_PWRITE", i), 32'(S_PWRITE), vecs[i].e_wr);
        chk($sformatf("v%0d S_PADDR", i), S_PADDR, vecs[i].e_adr);
        chk($sformatf("v%0d S_PWDATA", i), S_PWDATA, vecs[i].e_wd);
      end
    end

    // M1 write with 5 wait states then error
    set_m1(1, 1, 'hC, 'h5A5A);
    tick();
    chk("ws setup GNT", 32'(GNT), 2);
    chk("ws setup S_PENABLE", 32'(S_PENABLE), 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ws acc%0d S_PENABLE", i), 32'(S_PENABLE), 1);
      chk($sformatf("ws acc%0d S_PWDATA", i), S_PWDATA, 'h5A5A);
      chk($sformatf("ws acc%0d M1_PREADY", i), 32'(M1_PREADY), 0);
      set_s(i == 5, 'h1234, i == 5);
      tick();
    end
    chk("ws M1_PREADY", 32'(M1_PREADY), 1);
    chk("ws M1_PSLVERR", 32'(M1_PSLVERR), 1);
    chk("ws M1_PRDATA", M1_PRDATA, 0);
    chk("ws M0_PREADY", 32'(M0_PREADY), 0);
    chk("ws M0_PSLVERR", 32'(M0_PSLVERR), 0);
    set_s(0, 0, 0);
    set_m1(0, 0, 0, 0);
    tick();
    chk("ws idle M1_PREADY", 32'(M1_PREADY), 0);

    // M0 drops PSEL during SETUP: downstream completes, no PREADY
    set_m0(1, 0, 'h10, 0);
    tick();
    chk("drop setup S_PSEL", 32'(S_PSEL), 1);
    set_m0(0, 0, 0, 0);
    tick();
    chk("drop access S_PENABLE", 32'(S_PENABLE), 1);
    set_s(1, 'h77, 0);
    tick();
    chk("drop resp M0_PREADY", 32'(M0_PREADY), 0);
    chk("drop resp M0_PRDATA", M0_PRDATA, 0);
    chk("drop resp S_PSEL", 32'(S_PSEL), 0);
    set_s(0, 0, 0);
    tick();
    chk("drop idle GNT", 32'(GNT), 0);

    // reset during ACCESS, then M1 served normally
    set_m0(1, 0, 'h20, 0);
    tick();
    tick();
    chk("mrst access S_PENABLE", 32'(S_PENABLE), 1);
    RST = 1'b1;
    tick();
    chk("mrst S_PSEL", 32'(S_PSEL), 0);
    chk("mrst S_PENABLE", 32'(S_PENABLE), 0);
    chk("mrst GNT", 32'(GNT), 0);
    chk("mrst M0_PREADY", 32'(M0_PREADY), 0);
    RST = 1'b0;
    set_m0(0, 0, 0, 0);
    set_m1(1, 0, 'h24, 0);
    tick();
    chk("mrst m1 GNT", 32'(GNT), 2);
    chk("mrst m1 S_PADDR", S_PADDR, 'h24);
    chk("mrst m1 M0_PREADY", 32'(M0_PREADY), 0);
    tick();
    set_s(1, 'h99, 0);
    tick();
    chk("mrst m1 M1_PREADY", 32'(M1_PREADY), 1);
    chk("mrst m1 M1_PRDATA", M1_PRDATA, 'h99);
    chk("mrst m1 M0_PREADY", 32'(M0_PREADY), 0);
    set_s(0, 0, 0);
    set_m1(0, 0, 0, 0);
    tick();
    chk("mrst idle M1_PREADY", 32'(M1_PREADY), 0);

`ifdef ARB_TIMEOUT_EN
    // completer never ready: abort after 4 ACCESS cycles
    set_m0(1, 0, 'h30, 0);
    set_s(0, 'hBEEF, 0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo acc%0d S_PENABLE", i), 32'(S_PENABLE), 1);
      chk($sformatf("tmo acc%0d M0_PREADY", i), 32'(M0_PREADY), 0);
      tick();
    end
    chk("tmo M0_PREADY", 32'(M0_PREADY), 1);
    chk("tmo M0_PSLVERR", 32'(M0_PSLVERR), 1);
    chk("tmo M0_PRDATA", M0_PRDATA, 0);
    chk("tmo S_PSEL", 32'(S_PSEL), 0);
    set_s(1, 'hFF, 0);
    set_m0(0, 0, 0, 0);
    tick();
    chk("tmo late M0_PREADY", 32'(M0_PREADY), 0);
    chk("tmo late S_PSEL", 32'(S_PSEL), 0);
    chk("tmo late GNT", 32'(GNT), 0);
    set_s(0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
